// File: rtl/wallace_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier: partial products reduced by a row-wise
// Wallace tree of 3:2 compressors, ripple-carry final adder, registered product.
module wallace_multiplier #(
    parameter int unsigned WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   M
);

    localparam int unsigned PW = 2 * WIDTH;

    // Row count after l reduction layers: each group of three rows becomes two.
    function automatic int rows_at(input int w, input int l);
        int n;
        n = w;
        for (int k = 0; k < l; k++) begin
            n = (n / 3) * 2 + (n % 3);
        end
        return n;
    endfunction

    function automatic int num_layers(input int w);
        int n;
        int c;
        n = w;
        c = 0;
        while (n > 2) begin
            n = (n / 3) * 2 + (n % 3);
            c++;
        end
        return c;
    endfunction

    localparam int NL = num_layers(int'(WIDTH));

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Bitwise 3:2 compression of three rows; returns {carry_row << 1, sum_row}.
    function automatic logic [2*PW-1:0] csa(input logic [PW-1:0] x,
                                            input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
        logic [PW-1:0] s;
        logic [PW-1:0] c;
        logic [1:0]    t;
        for (int k = 0; k < int'(PW); k++) begin
            t    = fa(x[k], y[k], z[k]);
            s[k] = t[0];
            c[k] = t[1];
        end
        return {c << 1, s};
    endfunction

    for (genvar l = 0; l <= NL; l++) begin : g_lvl
        localparam int CN = rows_at(int'(WIDTH), l);
        logic [PW-1:0] r [CN];

        if (l == 0) begin : g_pp
            for (genvar i = 0; i < int'(WIDTH); i++) begin : g_row
                assign r[i] = PW'(A & {WIDTH{B[i]}}) << i;
            end
        end else begin : g_red
            localparam int PC = rows_at(int'(WIDTH), l - 1);
            localparam int G  = PC / 3;

            for (genvar g = 0; g < G; g++) begin : g_csa
                logic [2*PW-1:0] cs;
                assign cs         = csa(g_lvl[l-1].r[3*g], g_lvl[l-1].r[3*g+1],
                                        g_lvl[l-1].r[3*g+2]);
                assign r[2*g]     = cs[PW-1:0];
                assign r[2*g+1]   = cs[2*PW-1:PW];
            end

            // Rows left over after grouping pass straight to the next layer.
            for (genvar j = 0; j < PC - 3*G; j++) begin : g_pass
                assign r[2*G+j] = g_lvl[l-1].r[3*G+j];
            end
        end
    end

    logic [PW-1:0] row_x;
    logic [PW-1:0] row_y;
    logic [PW-1:0] prod_c;
    logic          ripple_c;
    logic [1:0]    bit_out;

    assign row_x = g_lvl[NL].r[0];
    assign row_y = g_lvl[NL].r[1];

    // Final carry-propagate adder; the carry out of the top bit is always 0.
    always_comb begin
        prod_c    = '0;
        bit_out   = ha(row_x[0], row_y[0]);
        prod_c[0] = bit_out[0];
        ripple_c  = bit_out[1];
        for (int k = 1; k < int'(PW); k++) begin
            bit_out   = fa(row_x[k], row_y[k], ripple_c);
            prod_c[k] = bit_out[0];
            ripple_c  = bit_out[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            M <= '0;
        end else begin
            M <= prod_c;
        end
    end

endmodule

// File: tb/tb_wallace_multiplier.sv
// Directed, sequence and random checks for the registered Wallace-tree multiplier.
module tb_wallace_multiplier;

    localparam int unsigned W = 12;

    logic            clk;
    logic            rst;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [2*W-1:0]  m;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] m;
    } vec_t;

    vec_t vecs [12];

    wallace_multiplier #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .A   (a),
        .B   (b),
        .M   (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] got,
                         input logic [2*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", name, got, exp);
        end
    endtask

    // Drive operands at the falling edge, sample just after the next rising edge.
    task automatic apply(input logic [W-1:0] va, input logic [W-1:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2*W-1:0] gold;
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{12'h456, 12'h678, 24'h1C0C50};
        vecs[1]  = '{12'hA12, 12'hB23, 24'h702676};
        vecs[2]  = '{12'hDAE, 12'h102, 24'h0DC95C};
        vecs[3]  = '{12'hFFF, 12'hFFF, 24'hFFE001};
        vecs[4]  = '{12'h000, 12'hABC, 24'h000000};
        vecs[5]  = '{12'h001, 12'h800, 24'h000800};
        vecs[6]  = '{12'h001, 12'h001, 24'h000001};
        vecs[7]  = '{12'hFFF, 12'h001, 24'h000FFF};
        vecs[8]  = '{12'h800, 12'h800, 24'h400000};
        vecs[9]  = '{12'h003, 12'h005, 24'h00000F};
        vecs[10] = '{12'h100, 12'h010, 24'h001000};
        vecs[11] = '{12'hFFF, 12'h000, 24'h000000};

        // Reset clears M without any clock edge.
        rst = 1'b1;
        a   = 12'h456;
        b   = 12'h678;
        #3;
        check("reset_no_edge", m, 24'h000000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_after_reset", m, 24'h1C0C50);

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), m, vecs[i].m);
        end

        // Mid-cycle operand change must not reach M before the next edge.
        apply(12'hA12, 12'hB23);
        check("latency_setup", m, 24'h702676);
        @(negedge clk);
        a = 12'hDAE;
        b = 12'h102;
        #2;
        check("latency_hold", m, 24'h702676);
        @(posedge clk);
        #1;
        check("latency_update", m, 24'h0DC95C);

        // Constant inputs hold a constant product across edges.
        @(posedge clk);
        #1;
        check("constant_hold", m, 24'h0DC95C);

        // Asynchronous reset between edges while a product is held.
        apply(12'hA12, 12'hB23);
        check("reset_setup", m, 24'h702676);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_clear", m, 24'h000000);
        a = 12'h456;
        b = 12'h678;
        @(posedge clk);
        #1;
        check("reset_held_over_edge", m, 24'h000000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_released_no_edge", m, 24'h000000);
        @(posedge clk);
        #1;
        check("after_reset_release", m, 24'h1C0C50);

        // Random operands against a golden product.
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            gold = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            apply(ra, rb);
            check($sformatf("rand%0d_%03h_%03h", i, ra, rb), m, gold);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
